mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-004 SHALL have port: data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-005 SHALL have port: ctrl_MULT  input  1  start-multiply pulse, sampled each rising edge.
REQ-006 SHALL have port: ctrl_DIV  input  1  start-divide pulse, sampled each rising edge.
REQ-007 SHALL have port: data_result  output  32  registered result.
REQ-008 SHALL have port: data_exception  output  1  registered exception flag, valid alongside the result.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL use one clock domain, with reset asynchronous and active-high.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV and DONE, encoded in registered state.
REQ-012 SHALL treat the sampling edge as the start edge when exactly one of ctrl_MULT or ctrl_DIV is high; operands latch on that edge and state enters MUL or DIV.
REQ-013 SHALL ignore the sampling edge when ctrl_MULT and ctrl_DIV are both high; state and outputs are unchanged.
REQ-014 SHALL abort any in-progress operation on a valid start edge in MUL or DIV; no RDY pulse is issued for the aborted operation, and the new operation restarts from iteration 0.
REQ-015 SHALL perform exactly 32 iterations in MUL or DIV, one per cycle, tracked by a 6-bit counter that is cleared on the start edge.
REQ-016 SHALL move to DONE after the 32nd iteration; data_resultRDY is high for exactly one cycle, on the 33rd rising edge after the start edge; DONE returns to IDLE on the following edge.
REQ-017 SHALL update data_result and data_exception on the same edge that asserts data_resultRDY, and hold them until the next completion or reset.
REQ-018 SHALL accept a start edge in DONE; it behaves as a start from IDLE, and the RDY pulse is still emitted that cycle.
REQ-019 SHALL multiply using radix-2 Booth recoding over a 65-bit product register; data_result is the low 32 bits of the signed 64-bit product.
REQ-020 SHALL set multiply data_exception = 1 when product bits [63:31] are not all equal, meaning the product does not fit in signed 32 bits.
REQ-021 SHALL divide by restoring division on magnitudes, with signs restored afterwards; the quotient truncates toward zero and the quotient sign is A[31] XOR B[31].
REQ-022 SHALL, when the divisor is 0, set data_result = 0 and data_exception = 1, with the full 33-cycle latency preserved.
REQ-023 SHALL, for 0x80000000 / 0xFFFFFFFF, set data_result = 0x80000000 and data_exception = 1.
REQ-024 SHALL set data_exception = 0 on all other divide results; the remainder is not output.
REQ-025 SHALL take operands only from the internal latched copies; data_operandA and data_operandB may change freely after the start edge.

Reset
REQ-026 SHALL, on reset assertion and independent of clock, force state = IDLE, counter = 0, data_result = 0x00000000, data_exception = 0 and data_resultRDY = 0.
REQ-027 SHALL abort any operation when reset is asserted mid-operation; no RDY pulse follows deassertion until a new start edge.
REQ-028 SHALL ignore start pulses while reset is high.

Verification
REQ-029 SHALL verify multiply: A=7, B=-6, MULT pulse -> RDY exactly 33 edges later, result 0xFFFFFFD6 (-42), exception 0.
REQ-030 SHALL verify multiply overflow: A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; A=0x80000000, B=1 -> result 0x80000000, exception 0.
REQ-031 SHALL verify divide: A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0; A=5, B=0 -> result 0, exception 1, RDY still at edge 33.
REQ-032 SHALL verify divide overflow: A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-033 SHALL verify restart: DIV start, then MULT start (A=3, B=4) 10 cycles later -> single RDY 33 edges after the second start, result 12; no RDY for the aborted divide.
REQ-034 SHALL verify reset and ignored starts: reset at cycle 15 of a multiply -> outputs 0, no RDY; ctrl_MULT and ctrl_DIV both high -> no RDY within 40 cycles.

Source files
------------

// File: rtl/mult_div.sv
// Signed 32x32 multiply (radix-2 Booth) and divide (restoring), one iteration per cycle.
// Latency 33 cycles start-to-RDY; no backpressure, a new start aborts the running op.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [64:0] prod;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        op_div;

  logic        start;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] quot_signed;
  logic [31:0] fin_result;
  logic        fin_exc;

  assign start = ctrl_MULT ^ ctrl_DIV;

  always_comb begin
    a_mag_in = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag    = b_reg[31] ? (~b_reg + 32'd1) : b_reg;

    // 33-bit accumulate so the most negative multiplicand cannot overflow the partial sum
    case (prod[1:0])
      2'b01:   booth_sum = {prod[64], prod[64:33]} + {a_reg[31], a_reg};
      2'b10:   booth_sum = {prod[64], prod[64:33]} - {a_reg[31], a_reg};
      default: booth_sum = {prod[64], prod[64:33]};
    endcase

    // Divide layout: remainder in prod[64:32], dividend/quotient bits in prod[31:0]
    div_shift = {prod[63:32], prod[31]};
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift - {1'b0, b_mag};

    quot_signed = (a_reg[31] ^ b_reg[31]) ? (~prod[31:0] + 32'd1) : prod[31:0];

    fin_result = 32'd0;
    fin_exc    = 1'b0;
    if (!op_div) begin
      fin_result = prod[32:1];
      fin_exc    = !((&prod[64:32]) || !(|prod[64:32]));
    end else if (b_reg == 32'd0) begin
      fin_result = 32'd0;
      fin_exc    = 1'b1;
    end else if (a_reg == 32'h8000_0000 && b_reg == 32'hFFFF_FFFF) begin
      fin_result = 32'h8000_0000;
      fin_exc    = 1'b1;
    end else begin
      fin_result = quot_signed;
      fin_exc    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 6'd0;
      prod           <= 65'd0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      op_div         <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == DONE) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
        data_resultRDY <= 1'b1;
      end

      if (start) begin
        a_reg  <= data_operandA;
        b_reg  <= data_operandB;
        op_div <= ctrl_DIV;
        count  <= 6'd0;
        state  <= ctrl_DIV ? DIV : MUL;
        prod   <= ctrl_DIV ? {33'd0, a_mag_in} : {32'd0, data_operandB, 1'b0};
      end else begin
        case (state)
          MUL: begin
            prod  <= {booth_sum, prod[32:1]};
            count <= count + 6'd1;
            if (count == 6'd31) state <= DONE;
          end
          DIV: begin
            prod  <= {(div_ge ? div_diff : div_shift), prod[30:0], div_ge};
            count <= count + 6'd1;
            if (count == 6'd31) state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Randomized and directed bench for mult_div against an arithmetic reference model.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  mult_div dut (
    .clock(clock),
    .reset(reset),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: operation outcome computed with plain integer arithmetic,
  // delivered 33 edges after the most recent start edge.
  int          m_cnt = -1;
  logic [31:0] pend_res;
  logic        pend_exc;
  logic [31:0] exp_res = 32'd0;
  logic        exp_exc = 1'b0;
  logic        exp_rdy = 1'b0;

  function automatic void model_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      r = p[31:0];
      e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt   = -1;
      exp_res = 32'd0;
      exp_exc = 1'b0;
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = 1'b0;
      if (m_cnt == 32) begin
        exp_rdy = 1'b1;
        exp_res = pend_res;
        exp_exc = pend_exc;
        m_cnt   = -1;
      end else if (m_cnt >= 0) begin
        m_cnt++;
      end
      if (ctrl_MULT ^ ctrl_DIV) begin
        model_op(ctrl_DIV, data_operandA, data_operandB, pend_res, pend_exc);
        m_cnt = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
    chk("cyc_result", data_result, exp_res);
    chk("cyc_exception", {31'd0, data_exception}, {31'd0, exp_exc});
  end

  // Caller is positioned just after a posedge; start edge is the next posedge.
  task automatic drive_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    #2;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(posedge clock);
    #2;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic count_rdy(input int n, output int first, output int cnt);
    first = -1;
    cnt = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic run_op(input string nm, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    int first, cnt;
    @(posedge clock);
    drive_start(!d, d, a, b);
    count_rdy(36, first, cnt);
    chk({nm, "_rdy_edge"}, first, 33);
    chk({nm, "_rdy_count"}, cnt, 1);
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exception"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int first, cnt;
    #22;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(posedge clock);
    #2 reset = 1'b0;

    run_op("mul_7x-6", 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_min_x1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by0", 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Divide aborted 10 cycles in by a multiply
    @(posedge clock);
    drive_start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    drive_start(1'b1, 1'b0, 32'd3, 32'd4);
    count_rdy(40, first, cnt);
    chk("restart_rdy_edge", first, 33);
    chk("restart_rdy_count", cnt, 1);
    chk("restart_result", data_result, 32'd12);

    // Reset 15 cycles into a multiply, with a start pulse held during reset
    @(posedge clock);
    drive_start(1'b1, 1'b0, 32'd5, 32'd9);
    repeat (14) @(posedge clock);
    #2;
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(posedge clock);
    #2 ctrl_MULT = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    count_rdy(40, first, cnt);
    chk("postreset_rdy_count", cnt, 0);
    chk("postreset_result", data_result, 32'd0);

    // Both start pulses high is not a start
    @(posedge clock);
    drive_start(1'b1, 1'b1, 32'd3, 32'd4);
    count_rdy(40, first, cnt);
    chk("both_high_rdy_count", cnt, 0);

    // Random ops with random spacing: aborts, starts in DONE, and idle gaps
    for (int i = 0; i < 80; i++) begin
      int sel;
      bit m, d;
      sel = $urandom_range(0, 9);
      m = (sel == 0) ? 1'b1 : (sel < 5);
      d = (sel == 0) ? 1'b1 : (sel >= 5);
      @(posedge clock);
      drive_start(m, d, pick_operand(), pick_operand());
      repeat ($urandom_range(0, 45)) @(posedge clock);
    end
    count_rdy(40, first, cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
